// File: rtl/pwm_seq_pkg.sv
// Shared types and register-map constants for the PWM step sequencer.
// Also holds the interval-sum helper used for the configuration check.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain
    } state_e;

    localparam logic [5:0] ADDR_SEQ_CFG = 6'h00;
    localparam logic [5:0] ADDR_FDIV_L  = 6'h01;
    localparam logic [5:0] ADDR_FDIV_H  = 6'h02;
    localparam logic [5:0] ENTRY_BASE   = 6'h20;

    localparam logic [2:0] F_PAT  = 3'd0;
    localparam logic [2:0] F_INT0 = 3'd1;
    localparam logic [2:0] F_INT1 = 3'd2;
    localparam logic [2:0] F_INT2 = 3'd3;
    localparam logic [2:0] F_INT3 = 3'd4;
    localparam logic [2:0] F_REP  = 3'd5;

    function automatic logic [9:0] interval_sum(input logic [3:0][7:0] iv);
        return 10'(iv[0]) + 10'(iv[1]) + 10'(iv[2]) + 10'(iv[3]);
    endfunction

endpackage

// File: rtl/pwm_seq_ctrl_table.sv
// Step table: DEPTH entries of six bytes, written byte-wise over the register bus,
// with one combinational read port indexed by the step being loaded.
module pwm_step_table
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clksys,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [5:0]      wr_addr,
    input  logic [7:0]      wr_data,
    input  logic [1:0]      rd_idx,
    output logic [7:0]      rd_pattern,
    output logic [3:0][7:0] rd_interval,
    output logic [7:0]      rd_repeat
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [5:0][7:0] mem_q [DEPTH];

    logic [1:0]      wr_entry;
    logic [2:0]      wr_field;
    logic            wr_hit;
    logic [IdxW-1:0] widx;
    logic [IdxW-1:0] ridx;

    assign wr_entry = wr_addr[4:3];
    assign wr_field = wr_addr[2:0];
    assign widx     = wr_entry[IdxW-1:0];
    assign ridx     = rd_idx[IdxW-1:0];
    // Fields 6/7 and entries beyond DEPTH are silently dropped.
    assign wr_hit   = wr_en && (wr_addr >= ENTRY_BASE) && ({1'b0, wr_entry} < 3'(DEPTH))
                      && (wr_field <= F_REP);

    always_ff @(posedge clksys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[widx][wr_field] <= wr_data;
        end
    end

    always_comb begin
        rd_pattern     = mem_q[ridx][F_PAT];
        rd_interval[0] = mem_q[ridx][F_INT0];
        rd_interval[1] = mem_q[ridx][F_INT1];
        rd_interval[2] = mem_q[ridx][F_INT2];
        rd_interval[3] = mem_q[ridx][F_INT3];
        rd_repeat      = mem_q[ridx][F_REP];
    end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM sequencer front-end: register bus decode, step FSM, repeat counter and the
// registered outputs that drive the PWM generator.
module pwm_seq_ctrl
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FDW   = 16
) (
    input  logic           clksys,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [5:0]     wr_addr,
    input  logic [7:0]     wr_data,
    input  logic           start,
    input  logic           stop,
    input  logic           period_done,
    output logic [7:0]     ctrl,
    output logic [FDW-1:0] fre_div,
    output logic [7:0]     pattern,
    output logic [7:0]     interval0,
    output logic [7:0]     interval1,
    output logic [7:0]     interval2,
    output logic [7:0]     interval3,
    output logic           busy,
    output logic [1:0]     step_idx,
    output logic           seq_done,
    output logic           cfg_err
);

    localparam logic [1:0] LastMax = 2'(DEPTH - 1);

    state_e state_q, state_d;
    logic [1:0]      step_q, step_d, last_eff;
    logic [7:0]      rep_cnt_q, rep_cnt_d;
    logic            stop_pend_q, stop_pend_d;
    logic            ctrl_en_q, ctrl_en_d;
    logic [FDW-1:0]  fre_div_q, fre_div_d;
    logic [7:0]      pattern_q, pattern_d;
    logic [3:0][7:0] interval_q, interval_d;
    logic            seq_done_q, seq_done_d;
    logic            cfg_err_q, cfg_err_d;
    logic            busy_q;
    logic [1:0]      last_step_q;
    logic            loop_q;
    logic [FDW-1:0]  fdiv_stage_q;
    logic            load;

    logic [7:0]      tbl_pattern, tbl_repeat;
    logic [3:0][7:0] tbl_interval;
    logic [FDW:0]    sum_ext, limit;

    // Read port follows the next step so an inline reload sees the new entry.
    pwm_step_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clksys      (clksys),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_idx      (step_d),
        .rd_pattern  (tbl_pattern),
        .rd_interval (tbl_interval),
        .rd_repeat   (tbl_repeat)
    );

    // fre_div wider than 8 and at most 16 bits: FDIV_H supplies the upper bits.
    always_ff @(posedge clksys or negedge rst_n) begin
        if (!rst_n) begin
            last_step_q  <= '0;
            loop_q       <= 1'b0;
            fdiv_stage_q <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_SEQ_CFG: {loop_q, last_step_q} <= wr_data[2:0];
                ADDR_FDIV_L:  fdiv_stage_q[7:0] <= wr_data;
                ADDR_FDIV_H:  fdiv_stage_q[FDW-1:8] <= wr_data[FDW-9:0];
                default: ;
            endcase
        end
    end

    assign last_eff = ({1'b0, last_step_q} >= 3'(DEPTH)) ? LastMax : last_step_q;
    assign sum_ext  = (FDW+1)'(interval_sum(tbl_interval));
    assign limit    = (FDW+1)'(fdiv_stage_q) + (FDW+1)'(1);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        rep_cnt_d   = rep_cnt_q;
        stop_pend_d = stop_pend_q;
        ctrl_en_d   = ctrl_en_q;
        fre_div_d   = fre_div_q;
        pattern_d   = pattern_q;
        interval_d  = interval_q;
        seq_done_d  = 1'b0;
        cfg_err_d   = cfg_err_q;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                ctrl_en_d = 1'b0;
                if (start && !stop) begin
                    state_d     = StLoad;
                    step_d      = 2'd0;
                    cfg_err_d   = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            StLoad: begin
                load    = 1'b1;
                state_d = StRun;
                if (stop) stop_pend_d = 1'b1;
            end
            StRun: begin
                if (stop || stop_pend_q) begin
                    state_d     = StDrain;
                    ctrl_en_d   = 1'b0;
                    stop_pend_d = 1'b0;
                end else if (period_done) begin
                    if (rep_cnt_q <= 8'd1) begin
                        if (step_q < last_eff) begin
                            step_d = step_q + 2'd1;
                            load   = 1'b1;
                        end else if (loop_q) begin
                            step_d = 2'd0;
                            load   = 1'b1;
                        end else begin
                            state_d   = StDrain;
                            ctrl_en_d = 1'b0;
                        end
                    end else begin
                        rep_cnt_d = rep_cnt_q - 8'd1;
                    end
                end
            end
            StDrain: begin
                ctrl_en_d = 1'b0;
                if (period_done) begin
                    state_d    = StIdle;
                    seq_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            pattern_d  = tbl_pattern;
            interval_d = tbl_interval;
            rep_cnt_d  = (tbl_repeat == 8'd0) ? 8'd1 : tbl_repeat;
            fre_div_d  = fdiv_stage_q;
            ctrl_en_d  = 1'b1;
            if (sum_ext > limit) cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clksys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            step_q      <= '0;
            rep_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            ctrl_en_q   <= 1'b0;
            fre_div_q   <= '0;
            pattern_q   <= '0;
            interval_q  <= '0;
            seq_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rep_cnt_q   <= rep_cnt_d;
            stop_pend_q <= stop_pend_d;
            ctrl_en_q   <= ctrl_en_d;
            fre_div_q   <= fre_div_d;
            pattern_q   <= pattern_d;
            interval_q  <= interval_d;
            seq_done_q  <= seq_done_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    assign ctrl      = {7'b0, ctrl_en_q};
    assign fre_div   = fre_div_q;
    assign pattern   = pattern_q;
    assign interval0 = interval_q[0];
    assign interval1 = interval_q[1];
    assign interval2 = interval_q[2];
    assign interval3 = interval_q[3];
    assign busy      = busy_q;
    assign step_idx  = step_q;
    assign seq_done  = seq_done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed self-checking bench for pwm_seq_ctrl: reset, one-shot, multi-step,
// looping, stop, cfg_err and staged fre_div scenarios with hand-computed values.
module tb_pwm_seq_ctrl;

    logic        clksys = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic        stop;
    logic        period_done;
    logic [7:0]  ctrl;
    logic [15:0] fre_div;
    logic [7:0]  pattern;
    logic [7:0]  interval0, interval1, interval2, interval3;
    logic        busy;
    logic [1:0]  step_idx;
    logic        seq_done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    pwm_seq_ctrl #(
        .DEPTH (4),
        .FDW   (16)
    ) dut (
        .clksys      (clksys),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .stop        (stop),
        .period_done (period_done),
        .ctrl        (ctrl),
        .fre_div     (fre_div),
        .pattern     (pattern),
        .interval0   (interval0),
        .interval1   (interval1),
        .interval2   (interval2),
        .interval3   (interval3),
        .busy        (busy),
        .step_idx    (step_idx),
        .seq_done    (seq_done),
        .cfg_err     (cfg_err)
    );

    always #5 clksys = ~clksys;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clksys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic pd();
        period_done = 1'b1;
        cyc();
        period_done = 1'b0;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; period_done = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset state
        chk("rst_ctrl", 32'(ctrl), 32'h0);
        chk("rst_fdiv", 32'(fre_div), 32'h0);
        chk("rst_pat", 32'(pattern), 32'h0);
        chk("rst_iv", {interval0, interval1, interval2, interval3}, 32'h0);
        chk("rst_misc", {28'h0, busy, step_idx, seq_done}, 32'h0);
        chk("rst_cfgerr", 32'(cfg_err), 32'h0);

        // Zeroed table: repeat 0 acts as 1, single step
        do_start();
        chk("z_ctrl_on", 32'(ctrl), 32'h1);
        chk("z_busy", 32'(busy), 32'h1);
        pd();
        chk("z_drain_ctrl", 32'(ctrl), 32'h0);
        chk("z_drain_busy", 32'(busy), 32'h1);
        period_done = 1'b1;
        cyc();
        period_done = 1'b0;
        chk("z_done", {30'h0, seq_done, busy}, 32'h2);
        cyc();
        chk("z_done_pulse", 32'(seq_done), 32'h0);
        chk("z_cfgerr", 32'(cfg_err), 32'h0);

        // Two entries, fre_div 49, last_step 1, no loop
        wr(6'h20, 8'h99); wr(6'h21, 8'd10); wr(6'h22, 8'd10); wr(6'h23, 8'd10);
        wr(6'h24, 8'd10); wr(6'h25, 8'd2);
        wr(6'h28, 8'h66); wr(6'h29, 8'd10); wr(6'h2A, 8'd10); wr(6'h2B, 8'd10);
        wr(6'h2C, 8'd10); wr(6'h2D, 8'd3);
        wr(6'h2E, 8'hFF);
        wr(6'h01, 8'd49); wr(6'h02, 8'd0); wr(6'h00, 8'h01);
        do_start();
        chk("s_load", {pattern, fre_div[7:0], interval0, interval3}, 32'h99310A0A);
        chk("s_step0", {step_idx, ctrl}, {2'd0, 8'h01});
        pd();
        chk("s_pd1_step", 32'(step_idx), 32'd0);
        pd();
        chk("s_pd2", {22'h0, step_idx, pattern}, {22'h0, 2'd1, 8'h66});
        pd();
        pd();
        chk("s_pd4", {23'h0, step_idx, ctrl[0], busy, seq_done, 4'h0}, {23'h0, 2'd1, 3'b110, 4'h0});
        pd();
        chk("s_pd5_off", {30'h0, ctrl[0], busy}, 32'h1);
        period_done = 1'b1;
        cyc();
        period_done = 1'b0;
        chk("s_pd6_done", {30'h0, seq_done, busy}, 32'h2);
        cyc();

        // Loop enabled: 0,0,1,1,1,0 with no gap at the wrap
        wr(6'h00, 8'h05);
        do_start();
        pd();
        chk("l_pd1", 32'(step_idx), 32'd0);
        pd();
        chk("l_pd2", 32'(step_idx), 32'd1);
        pd();
        pd();
        chk("l_pd4", 32'(step_idx), 32'd1);
        period_done = 1'b1;
        cyc();
        period_done = 1'b0;
        chk("l_wrap", {22'h0, step_idx, pattern}, {22'h0, 2'd0, 8'h99});
        chk("l_wrap_on", {30'h0, ctrl[0], busy}, 32'h3);
        cyc();
        pd();
        pd();
        chk("l_pd7", 32'(step_idx), 32'd1);

        // Stop at step 1
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        chk("stop_ctrl", {29'h0, ctrl[0], busy, seq_done}, 32'h2);
        period_done = 1'b1;
        cyc();
        period_done = 1'b0;
        chk("stop_done", {30'h0, seq_done, busy}, 32'h2);
        cyc();

        // start and stop together in IDLE do nothing
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        cyc();
        chk("ss_idle", {30'h0, busy, ctrl[0]}, 32'h0);

        // Interval sum 400 against fre_div 99
        wr(6'h21, 8'd100); wr(6'h22, 8'd100); wr(6'h23, 8'd100); wr(6'h24, 8'd100);
        wr(6'h01, 8'd99); wr(6'h00, 8'h00);
        do_start();
        chk("ce_set", 32'(cfg_err), 32'h1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        pd();
        chk("ce_sticky", {30'h0, cfg_err, busy}, 32'h2);

        // Staged fre_div applied only at a step load
        wr(6'h21, 8'd10); wr(6'h22, 8'd10); wr(6'h23, 8'd10); wr(6'h24, 8'd10);
        wr(6'h00, 8'h01);
        do_start();
        chk("ce_clear", 32'(cfg_err), 32'h0);
        chk("fd_99", 32'(fre_div), 32'd99);
        wr(6'h01, 8'd199);
        chk("fd_hold", 32'(fre_div), 32'd99);
        pd();
        chk("fd_hold_pd1", 32'(fre_div), 32'd99);
        pd();
        chk("fd_new", {22'h0, step_idx, fre_div[7:0]}, {22'h0, 2'd1, 8'd199});

        // Asynchronous reset mid-RUN
        rst_n = 1'b0;
        #1;
        chk("ar_ctrl_fdiv", {ctrl, 8'h0, fre_div}, 32'h0);
        chk("ar_pat_iv", {pattern, interval0, interval1, interval3}, 32'h0);
        chk("ar_misc", {27'h0, busy, step_idx, seq_done, cfg_err}, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
